// File: rtl/comp_pkg.sv
// rtl/comp_pkg.sv - shared types and constants for the serial magnitude comparator
package comp_pkg;

   localparam int DEFAULT_WIDTH = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Counter must reach WIDTH itself without wrapping.
   function automatic int cnt_bits(input int width);
      return $clog2(width + 1);
   endfunction

endpackage

// File: rtl/comp_serial_if.sv
// rtl/comp_serial_if.sv - handshake and result bundle of the serial comparator
interface comp_serial_if;

   logic start;
   logic bit_valid;
   logic x;
   logic y;
   logic busy;
   logic done;
   logic eq;
   logic gt;
   logic lt;

   modport master (
      output start, bit_valid, x, y,
      input  busy, done, eq, gt, lt
   );

   modport slave (
      input  start, bit_valid, x, y,
      output busy, done, eq, gt, lt
   );

endinterface

// File: rtl/comp_bit_cell.sv
// rtl/comp_bit_cell.sv - per-bit equality and greater-than decision
module comp_bit_cell (
   input  logic x,
   input  logic y,
   output logic bit_eq,
   output logic bit_gt
);

   assign bit_eq = ~(x ^ y);
   assign bit_gt = x & ~y;

endmodule

// File: rtl/comp_serial.sv
// rtl/comp_serial.sv - MSB-first serial unsigned comparator; gt/lt only with COMP_SERIAL_MAG_EN
module comp_serial
   import comp_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic          clk,
   input  logic          rst,
   comp_serial_if.slave  bus
);

   localparam int             CW   = cnt_bits(WIDTH);
   localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

   state_t         state;
   state_t         state_nxt;
   logic [CW-1:0]  cnt;
   logic           decided;
   logic           eq_q;

   logic           cell_eq;
   logic           cell_gt;
   logic           accept;
   logic           take;
   logic           last_bit;
   logic           new_diff;
   logic           decided_nxt;

   comp_bit_cell u_cell (
      .x      (bus.x),
      .y      (bus.y),
      .bit_eq (cell_eq),
      .bit_gt (cell_gt)
   );

   always_comb begin
      accept      = bus.start && (state == S_IDLE || state == S_DONE);
      take        = (state == S_SHIFT) && bus.bit_valid;
      last_bit    = take && (cnt == LAST);
      new_diff    = take && !decided && !cell_eq;
      decided_nxt = decided | new_diff;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:  if (accept) state_nxt = S_SHIFT;
         S_SHIFT: if (last_bit) state_nxt = S_DONE;
         S_DONE:  state_nxt = accept ? S_SHIFT : S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // Pairs after the decision are still counted so done timing never depends on data.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt     <= '0;
         decided <= 1'b0;
         eq_q    <= 1'b0;
      end else if (accept) begin
         cnt     <= '0;
         decided <= 1'b0;
         eq_q    <= 1'b0;
      end else if (take) begin
         cnt     <= cnt + CW'(1);
         decided <= decided_nxt;
         if (last_bit) eq_q <= ~decided_nxt;
      end
   end

`ifdef COMP_SERIAL_MAG_EN
   logic gt_rec;
   logic gt_fin;
   logic gt_q;
   logic lt_q;

   assign gt_fin = new_diff ? cell_gt : gt_rec;

   always_ff @(posedge clk) begin
      if (rst) begin
         gt_rec <= 1'b0;
         gt_q   <= 1'b0;
         lt_q   <= 1'b0;
      end else if (accept) begin
         gt_rec <= 1'b0;
         gt_q   <= 1'b0;
         lt_q   <= 1'b0;
      end else if (take) begin
         if (new_diff) gt_rec <= cell_gt;
         if (last_bit) begin
            gt_q <= decided_nxt & gt_fin;
            lt_q <= decided_nxt & ~gt_fin;
         end
      end
   end

   assign bus.gt = gt_q;
   assign bus.lt = lt_q;
`else
   logic unused_cell_gt;
   assign unused_cell_gt = cell_gt;

   assign bus.gt = 1'b0;
   assign bus.lt = 1'b0;
`endif

   assign bus.busy = (state == S_SHIFT);
   assign bus.done = (state == S_DONE);
   assign bus.eq   = eq_q;

endmodule

// File: tb/tb_comp_serial.sv
// tb/tb_comp_serial.sv - directed self-checking bench for comp_serial
module tb_comp_serial;

   localparam int W = 8;
`ifdef COMP_SERIAL_MAG_EN
   localparam logic MAG = 1'b1;
`else
   localparam logic MAG = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst;
   int   n_cmp = 0;
   int   n_bad = 0;
   bit   chain = 1'b0;

   always #5 clk = ~clk;

   comp_serial_if bus ();

   comp_serial #(.WIDTH(W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [2:0] flags();
      return {bus.eq, bus.gt, bus.lt};
   endfunction

   // exp is {eq,gt,lt}; gt/lt collapse to 0 when magnitude is not built in
   task automatic run_word(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                           input int stall_at, input int stall_len, input int poke_at,
                           input bit valid_on_start, input logic [2:0] exp, input int exp_lat);
      int i = 0;
      int cyc = 0;
      int stalled = 0;
      int busy_lo = 0;
      int flag_hi = 0;
      if (!chain) @(negedge clk);
      chain = 1'b0;
      bus.start     = 1'b1;
      bus.bit_valid = valid_on_start;
      bus.x         = 1'b1;
      bus.y         = 1'b0;
      while (cyc < 40) begin
         @(negedge clk);
         cyc++;
         if (bus.done) break;
         if (!bus.busy) busy_lo++;
         if (flags() != 3'b000) flag_hi++;
         bus.start = (i == poke_at);
         if (i < W) begin
            if (i == stall_at && stalled < stall_len) begin
               bus.bit_valid = 1'b0;
               stalled++;
            end else begin
               bus.bit_valid = 1'b1;
               bus.x = a[W-1-i];
               bus.y = b[W-1-i];
               i++;
            end
         end else begin
            bus.bit_valid = 1'b0;
         end
      end
      bus.start     = 1'b0;
      bus.bit_valid = 1'b0;
      chk({tag, "/latency"}, cyc, exp_lat);
      chk({tag, "/busy_low_in_shift"}, busy_lo, 0);
      chk({tag, "/flags_before_done"}, flag_hi, 0);
      chk({tag, "/result"}, flags(), exp & {1'b1, MAG, MAG});
      chk({tag, "/busy_at_done"}, bus.busy, 1'b0);
   endtask

   task automatic idle_after(input string tag, input logic [2:0] exp);
      @(negedge clk);
      chk({tag, "/done_one_cycle"}, bus.done, 1'b0);
      chk({tag, "/idle_busy"}, bus.busy, 1'b0);
      chk({tag, "/result_held"}, flags(), exp & {1'b1, MAG, MAG});
   endtask

   initial begin
      rst           = 1'b1;
      bus.start     = 1'b0;
      bus.bit_valid = 1'b0;
      bus.x         = 1'b0;
      bus.y         = 1'b0;
      repeat (2) @(negedge clk);
      chk("reset/busy", bus.busy, 1'b0);
      chk("reset/done", bus.done, 1'b0);
      chk("reset/flags", flags(), 3'b000);
      rst = 1'b0;

      run_word("a5_eq", 8'hA5, 8'hA5, -1, 0, -1, 1'b0, 3'b100, 9);
      idle_after("a5_eq", 3'b100);

      run_word("80_gt", 8'h80, 8'h7F, -1, 0, -1, 1'b0, 3'b010, 9);
      idle_after("80_gt", 3'b010);

      run_word("3c_lt_stall", 8'h3C, 8'h3D, 4, 3, -1, 1'b0, 3'b001, 12);
      idle_after("3c_lt_stall", 3'b001);

      run_word("valid_on_start", 8'h5A, 8'h5A, -1, 0, -1, 1'b1, 3'b100, 9);
      idle_after("valid_on_start", 3'b100);

      run_word("start_in_shift", 8'h12, 8'h34, -1, 0, 3, 1'b0, 3'b001, 9);
      idle_after("start_in_shift", 3'b001);

      run_word("ff_00", 8'hFF, 8'h00, -1, 0, -1, 1'b0, 3'b010, 9);
      chain = 1'b1;
      run_word("start_in_done", 8'h01, 8'h02, -1, 0, -1, 1'b0, 3'b001, 9);
      idle_after("start_in_done", 3'b001);

      // Abandon a word after four bits, with the result already decided.
      @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      for (int k = 0; k < 4; k++) begin
         bus.bit_valid = 1'b1;
         bus.x = 1'b1;
         bus.y = 1'b0;
         @(negedge clk);
      end
      chk("mid_rst/busy_before", bus.busy, 1'b1);
      rst = 1'b1;
      bus.start = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      bus.start = 1'b0;
      chk("mid_rst/busy", bus.busy, 1'b0);
      chk("mid_rst/done", bus.done, 1'b0);
      chk("mid_rst/flags", flags(), 3'b000);
      repeat (3) @(negedge clk);
      chk("idle_ignores_valid/busy", bus.busy, 1'b0);
      chk("idle_ignores_valid/done", bus.done, 1'b0);
      bus.bit_valid = 1'b0;
      run_word("after_rst", 8'h5A, 8'h5B, -1, 0, -1, 1'b0, 3'b001, 9);
      idle_after("after_rst", 3'b001);

      run_word("rst_clears", 8'hA5, 8'hA5, -1, 0, -1, 1'b0, 3'b100, 9);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("rst_clears/flags", flags(), 3'b000);
      chk("rst_clears/done", bus.done, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/comp_serial.md
COMP_SERIAL -- requirements
Module: comp_serial

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the number of bits per compared word (legal range 2..32).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates occur on its rising edge.
REQ-003 SHALL have port rst  input  1  reset; synchronous and active-high.
REQ-004 SHALL have port start  input  1  request to begin a new comparison.
REQ-005 SHALL have port bit_valid  input  1  qualifies x and y as a bit pair in the current cycle.
REQ-006 SHALL have port x  input  1  serial operand A, MSB first.
REQ-007 SHALL have port y  input  1  serial operand B, MSB first.
REQ-008 SHALL have port busy  output  1  high while a comparison is in progress.
REQ-009 SHALL have port done  output  1  one-cycle pulse when the result becomes valid.
REQ-010 SHALL have port eq  output  1  A equals B.
REQ-011 SHALL have port gt  output  1  A greater than B, unsigned.
REQ-012 SHALL have port lt  output  1  A less than B, unsigned.

Function
REQ-013 SHALL implement states IDLE, SHIFT and DONE.
REQ-014 SHALL move IDLE->SHIFT on start, clearing the bit counter, the decided flag and eq/gt/lt.
REQ-015 SHALL ignore bit_valid in the cycle that start is accepted.
REQ-016 SHALL consume one bit pair per cycle in SHIFT when bit_valid=1; bit_valid=0 stalls with state held.
REQ-017 SHALL, on the first consumed pair with x!=y while not decided, set decided=1 and record gt=x, lt=~x.
REQ-018 SHALL ignore all later pairs for the result once decided=1, while still counting them.
REQ-019 SHALL go SHIFT->DONE after the WIDTH-th consumed pair, so that done=1 in the following cycle, with eq=~decided and with gt/lt as recorded.
REQ-020 SHALL hold done for exactly one cycle, then return DONE->IDLE; eq/gt/lt stay stable until the next accepted start.
REQ-021 SHALL accept start while in DONE and go directly to SHIFT.
REQ-022 SHALL ignore start while in SHIFT.
REQ-023 SHALL drive busy=1 exactly when in SHIFT.
REQ-024 SHALL assert at most one of eq/gt/lt at any time; all three are 0 from the accepted start until done.
REQ-025 SHALL size the bit counter as $clog2(WIDTH+1) bits, with no wrap before WIDTH.

Reset
REQ-026 SHALL, on rst=1, enter IDLE and drive busy=0, done=0, eq=0, gt=0 and lt=0, clearing the counter and the decided flag.
REQ-027 SHALL abandon an in-progress comparison on rst=1, which has priority over start and bit_valid.

Configuration
REQ-028 SHALL, with macro COMP_SERIAL_MAG_EN defined, implement gt/lt as specified.
REQ-029 SHALL, without COMP_SERIAL_MAG_EN, tie gt and lt to 0, omit the magnitude register, and leave eq, done and busy behaviour unchanged.

Structure
REQ-030 SHALL place the state enum type and the default WIDTH constant in package comp_pkg.
REQ-031 SHALL use one combinational sub-module, comp_bit_cell (inputs x, y; outputs bit_eq, bit_gt), for the per-bit decision.

Verification
REQ-032 SHALL cover: WIDTH=8, A=0xA5, B=0xA5 contiguous -> done 9 cycles after start, eq=1, gt=0, lt=0.
REQ-033 SHALL cover: A=0x80, B=0x7F -> gt=1 decided on the first bit, lt=0, eq=0, done still after 8 bits.
REQ-034 SHALL cover: A=0x3C, B=0x3D with bit_valid low for 3 cycles mid-word -> lt=1, done delayed by 3 cycles, busy high throughout.
REQ-035 SHALL cover: start pulsed during SHIFT, and start with bit_valid in the same cycle -> both ignored, result unaffected.
REQ-036 SHALL cover: rst asserted after 4 bits -> next cycle IDLE, all outputs 0; a fresh start then completes correctly.
REQ-037 SHALL cover: a build without COMP_SERIAL_MAG_EN, A=0xFF, B=0x00 -> eq=0, gt=0, lt=0, done pulses.
